// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the system ID (addr 0) and timestamp (addr 1) words and compares them.
// Optional read-stall timeout is built when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1554196137,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic        address_q, address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        accept;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

  // read_q is only ever high in RD_ID/RD_TS, so this is the Avalon accept.
  assign accept = read_q && !waitrequest;

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    address_d  = address_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
`ifdef SYSID_CHECK_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        read_d    = 1'b0;
        address_d = 1'b0;
        if (start) begin
          state_d    = RD_ID;
          read_d     = 1'b1;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
`ifdef SYSID_CHECK_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      RD_ID: begin
        if (accept) begin
          id_value_d = readdata;
          address_d  = 1'b1;
          state_d    = RD_TS;
`ifdef SYSID_CHECK_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      RD_TS: begin
        if (accept) begin
          ts_value_d = readdata;
          read_d     = 1'b0;
          state_d    = DONE;
`ifdef SYSID_CHECK_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      DONE: begin
        read_d    = 1'b0;
        address_d = 1'b0;
        done_d    = 1'b1;
        pass_d    = !timeout_q && (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
        state_d   = IDLE;
      end
      default: begin
        state_d   = IDLE;
        read_d    = 1'b0;
        address_d = 1'b0;
      end
    endcase

`ifdef SYSID_CHECK_TIMEOUT_EN
    // Stall cycle: count it, and abandon the read once the limit is reached.
    if ((state_q == RD_ID || state_q == RD_TS) && read_q && waitrequest) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
      if (wait_cnt_d == TIMEOUT_LIM) begin
        read_d    = 1'b0;
        timeout_d = 1'b1;
        state_d   = DONE;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      address_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
`ifdef SYSID_CHECK_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      address_q  <= address_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
`ifdef SYSID_CHECK_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign read     = read_q;
  assign address  = address_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: doc/sysid_check_master.md
SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter EXPECTED_ID, default 32'h00000000: value the ID word (slave address 0) is required to return.
REQ-003 Parameter EXPECTED_TS, default 32'd1554196137: value the timestamp word (slave address 1) is required to return.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, legal range 1..65535: number of waitrequest-high cycles tolerated per read.
REQ-005 Port clock, input, 1: the single clock; all flops are rising-edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: a one-cycle request to begin a check, sampled only in IDLE.
REQ-008 Port address, output, 1: Avalon-MM master word address (0 = ID, 1 = timestamp).
REQ-009 Port read, output, 1: Avalon-MM read strobe.
REQ-010 Port waitrequest, input, 1: slave stall; a read is accepted on a cycle with read=1 and waitrequest=0.
REQ-011 Port readdata, input, 32: slave read data, valid on the accept cycle (zero read latency).
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: a one-cycle pulse when a check completes or times out.
REQ-014 Port pass, output, 1: check result; it is sticky until the next accepted start.
REQ-015 Port timeout, output, 1: timeout flag; it is sticky until the next accepted start.
REQ-016 Port id_value, output, 32: the captured ID word.
REQ-017 Port ts_value, output, 32: the captured timestamp word.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_ID, RD_TS and DONE, with all outputs registered.
REQ-019 IDLE with start=1 SHALL go to RD_ID and clear pass, timeout, id_value and ts_value.
REQ-020 In RD_ID, read=1 and address=0 SHALL be held until accept; on accept, readdata goes to id_value and the FSM goes to RD_TS.
REQ-021 In RD_TS, read=1 and address=1 SHALL be held until accept; on accept, readdata goes to ts_value and the FSM goes to DONE.
REQ-022 The read strobe SHALL stay continuously high across the RD_ID->RD_TS transition, and address SHALL change only in the cycle after an accept.
REQ-023 In DONE, done=1 for exactly one cycle, read=0, pass = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS), and the next state is IDLE.
REQ-024 Latency with waitrequest tied low: start sampled on edge N; accepts on edges N+1 and N+2; done and pass visible in the cycle after edge N+3.
REQ-025 read SHALL never be asserted in IDLE or DONE, and address SHALL be 0 in IDLE.
REQ-026 start SHALL be ignored in RD_ID, RD_TS and DONE, with no queuing.
REQ-027 readdata SHALL be sampled only on accept cycles, and ignored otherwise.
REQ-028 A mismatch in either word SHALL give pass=0, with both captured words still reported.

Reset
REQ-029 Reset assertion SHALL immediately force state=IDLE, read=0, address=0, busy=0, done=0, pass=0, timeout=0, id_value=0, ts_value=0 and wait counter=0.
REQ-030 Reset asserted mid-read SHALL drop read asynchronously, with no done pulse.
REQ-031 After release, the first accepted start SHALL be on the first rising edge with reset low.

Configuration
REQ-032 Macro SYSID_CHECK_TIMEOUT_EN defined: a 16-bit wait counter clears on entry to RD_ID and RD_TS and on every accept, and increments each cycle with read=1 and waitrequest=1.
REQ-033 With SYSID_CHECK_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES: read=0 next cycle, timeout=1, pass=0, go to DONE (done pulse), and leave the uncaptured word at 0.
REQ-034 SYSID_CHECK_TIMEOUT_EN undefined: no counter is built, timeout is tied 0, and the master waits indefinitely on waitrequest.

Verification
REQ-035 waitrequest=0, slave returns 0 / 1554196137, start pulse -> two reads (addr 0 then 1) on consecutive cycles; done at start+3; pass=1; id_value=0; ts_value=1554196137.
REQ-036 Slave returns ts=32'h12345678 -> done pulse; pass=0; ts_value=32'h12345678; timeout=0.
REQ-037 waitrequest high 3 cycles on each read -> read stays high and address stays stable while stalled; done at start+9; pass=1.
REQ-038 With SYSID_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high -> read drops after 4 stall cycles; timeout=1; pass=0; one done pulse; busy=0 afterwards.
REQ-039 Reset asserted while in RD_TS -> read=0 and busy=0 asynchronously; all outputs 0; a fresh start after release passes normally.
REQ-040 start pulsed again while busy, and start held high through DONE -> the extra start is ignored, and a new check begins only from IDLE.
